// File: rtl/lif_pkg.sv
// Shared types and arithmetic helpers for the LIF neuron array.
package lif_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  localparam int unsigned SatMaxW = 32;

  // Unsigned add clamped to 2^w - 1; callers pass operands narrower than SatMaxW.
  function automatic logic [SatMaxW-1:0] sat_add(input logic [SatMaxW-1:0] a,
                                                 input logic [SatMaxW-1:0] b,
                                                 input int unsigned w);
    logic [SatMaxW:0] sum;
    logic [SatMaxW:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = ((SatMaxW + 1)'(1) << w) - (SatMaxW + 1)'(1);
    if (sum > lim) begin
      return lim[SatMaxW-1:0];
    end
    return sum[SatMaxW-1:0];
  endfunction

endpackage

// File: rtl/lif_array_if.sv
// Control, stimulus and readout bundle between the LIF array and its driver.
interface lif_array_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = $clog2(N),
  parameter int unsigned REF_W = 4
) ();

  logic               step;
  logic [N*WIDTH-1:0] current;
  logic [WIDTH-1:0]   threshold;
  logic [2:0]         leak_shift;
  logic [REF_W-1:0]   refract;
  logic               busy;
  logic               done;
  logic [N-1:0]       spikes;
  logic [IDX_W-1:0]   rd_idx;
  logic [WIDTH-1:0]   rd_state;

  modport master (
    output step, current, threshold, leak_shift, refract, rd_idx,
    input  busy, done, spikes, rd_state
  );

  modport slave (
    input  step, current, threshold, leak_shift, refract, rd_idx,
    output busy, done, spikes, rd_state
  );

endinterface

// File: rtl/lif_update.sv
// Combinational single-neuron update: refractory hold, leak, saturating integrate, fire/reset.
module lif_update
  import lif_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned REF_W = 4
) (
  input  logic [WIDTH-1:0] i_s,
  input  logic [WIDTH-1:0] i_c,
  input  logic [WIDTH-1:0] i_threshold,
  input  logic [2:0]       i_leak_shift,
  input  logic [REF_W-1:0] i_ref_cnt,
  input  logic [REF_W-1:0] i_refract,
  output logic [WIDTH-1:0] o_state,
  output logic [REF_W-1:0] o_ref_cnt,
  output logic             o_spike
);

  logic [WIDTH-1:0] w_v;
  logic [WIDTH-1:0] w_n;

  always_comb begin
    // s - (s >> k) never underflows, so no guard is needed on the subtract.
    w_v = (i_leak_shift != 3'd0) ? (i_s - (i_s >> i_leak_shift)) : i_s;
    w_n = WIDTH'(sat_add(SatMaxW'(w_v), SatMaxW'(i_c), WIDTH));

    o_state   = w_n;
    o_ref_cnt = '0;
    o_spike   = 1'b0;
    if (i_ref_cnt != '0) begin
      o_state   = '0;
      o_ref_cnt = i_ref_cnt - REF_W'(1);
    end else if (w_n >= i_threshold) begin
      o_state   = '0;
      o_ref_cnt = i_refract;
      o_spike   = 1'b1;
    end
  end

endmodule

// File: rtl/lif_array.sv
// Time-multiplexed array of N LIF neurons sharing one lif_update datapath.
// Define LIF_REFRACTORY_EN to build per-neuron refractory counters.
module lif_array
  import lif_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = $clog2(N),
  parameter int unsigned REF_W = 4
) (
  input logic        clk,
  input logic        reset_n,
  lif_array_if.slave bus
);

  state_e r_state;
  state_e w_state_next;

  logic [IDX_W-1:0]   r_idx;
  logic [N*WIDTH-1:0] r_cur;
  logic [WIDTH-1:0]   r_thr;
  logic [2:0]         r_leak;
  logic [WIDTH-1:0]   r_mem [N];
  logic [N-1:0]       r_shadow;
  logic [N-1:0]       r_spikes;
  logic [WIDTH-1:0]   r_rd_state;

  logic               w_last;
  logic               w_accept;
  logic [WIDTH-1:0]   w_s;
  logic [WIDTH-1:0]   w_c;
  logic [REF_W-1:0]   w_ref_cur;
  logic [REF_W-1:0]   w_refract;
  logic [WIDTH-1:0]   w_mem_next;
  logic [REF_W-1:0]   w_ref_next;
  logic               w_spike;
  logic [N-1:0]       w_shadow_next;

  assign w_last   = (r_idx == IDX_W'(N - 1));
  assign w_accept = bus.step && (r_state == StIdle);
  assign w_s      = r_mem[r_idx];
  assign w_c      = r_cur[r_idx*WIDTH +: WIDTH];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (bus.step) w_state_next = StRun;
      StRun:   if (w_last) w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    bus.busy = (r_state != StIdle);
    bus.done = (r_state == StDone);
  end

  lif_update #(
    .WIDTH (WIDTH),
    .REF_W (REF_W)
  ) u_update (
    .i_s          (w_s),
    .i_c          (w_c),
    .i_threshold  (r_thr),
    .i_leak_shift (r_leak),
    .i_ref_cnt    (w_ref_cur),
    .i_refract    (w_refract),
    .o_state      (w_mem_next),
    .o_ref_cnt    (w_ref_next),
    .o_spike      (w_spike)
  );

  always_comb begin
    w_shadow_next        = r_shadow;
    w_shadow_next[r_idx] = w_spike;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_idx      <= '0;
      r_cur      <= '0;
      r_thr      <= '0;
      r_leak     <= '0;
      r_shadow   <= '0;
      r_spikes   <= '0;
      r_rd_state <= '0;
      for (int i = 0; i < N; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_rd_state <= r_mem[bus.rd_idx];
      if (w_accept) begin
        r_idx    <= '0;
        r_cur    <= bus.current;
        r_thr    <= bus.threshold;
        r_leak   <= bus.leak_shift;
        r_shadow <= '0;
      end else if (r_state == StRun) begin
        r_mem[r_idx] <= w_mem_next;
        r_shadow     <= w_shadow_next;
        r_idx        <= r_idx + IDX_W'(1);
        // Published on entry to DONE so spikes are valid while done is high.
        if (w_last) begin
          r_spikes <= w_shadow_next;
        end
      end
    end
  end

`ifdef LIF_REFRACTORY_EN
  logic [REF_W-1:0] r_ref [N];
  logic [REF_W-1:0] r_refract;

  assign w_ref_cur = r_ref[r_idx];
  assign w_refract = r_refract;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_refract <= '0;
      for (int i = 0; i < N; i++) begin
        r_ref[i] <= '0;
      end
    end else if (w_accept) begin
      r_refract <= bus.refract;
    end else if (r_state == StRun) begin
      r_ref[r_idx] <= w_ref_next;
    end
  end
`else
  logic w_unused_ref;

  assign w_ref_cur    = '0;
  assign w_refract    = '0;
  assign w_unused_ref = ^{bus.refract, w_ref_next};
`endif

  assign bus.spikes   = r_spikes;
  assign bus.rd_state = r_rd_state;

endmodule

// File: tb/tb_lif_array.sv
// Self-checking bench for lif_array: directed tables, corner sequences, random vs. model.
module tb_lif_array;

  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  lif_array_if #(.WIDTH(W), .N(N), .IDX_W(2), .REF_W(4)) bus ();

  lif_array #(.WIDTH(W), .N(N), .IDX_W(2), .REF_W(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int total = 0;
  int bad = 0;
  int m_mem[N];
  int m_ref[N];

  typedef struct {
    logic [31:0] cur;
    int          thr;
    int          ls;
    int          rf;
    int          exp_spk;
    int          exp_mem;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_mem[i] = 0;
      m_ref[i] = 0;
    end
  endtask

  // Behavioural sweep: integer arithmetic straight from the neuron rules.
  function automatic int model_step(input logic [31:0] cur, input int thr, input int ls,
                                    input int rf);
    int mask = 0;
    for (int i = 0; i < N; i++) begin
      int s = m_mem[i];
      int c = int'(cur[i*8 +: 8]);
      int v;
      int n;
`ifdef LIF_REFRACTORY_EN
      if (m_ref[i] > 0) begin
        m_ref[i] = m_ref[i] - 1;
        m_mem[i] = 0;
        continue;
      end
`endif
      v = (ls == 0) ? s : s - (s >> ls);
      n = v + c;
      if (n > 255) n = 255;
      if (n >= thr) begin
        mask = mask | (1 << i);
        m_mem[i] = 0;
        m_ref[i] = rf;
      end else begin
        m_mem[i] = n;
      end
    end
    return mask;
  endfunction

  task automatic do_reset();
    bus.step = 1'b0;
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    model_clear();
  endtask

  task automatic read_mem(input int idx, output int val);
    bus.rd_idx = 2'(idx);
    tick();
    val = int'(bus.rd_state);
  endtask

  // One accepted sweep; returns DUT spikes and the model's expectation.
  task automatic run_step(input logic [31:0] cur, input int thr, input int ls, input int rf,
                          output int spk, output int exp_spk);
    int k = 0;
    bus.current    = cur;
    bus.threshold  = 8'(thr);
    bus.leak_shift = 3'(ls);
    bus.refract    = 4'(rf);
    bus.step       = 1'b1;
    tick();
    bus.step = 1'b0;
    // Scramble inputs to show the sweep uses the latched copies.
    bus.current    = $urandom;
    bus.threshold  = 8'($urandom);
    bus.leak_shift = 3'($urandom);
    bus.refract    = 4'($urandom);
    while (!bus.done && k < 20) begin
      tick();
      k++;
    end
    check("done_latency", k, N);
    spk = int'(bus.spikes);
    exp_spk = model_step(cur, thr, ls, rf);
    tick();
    check("done_one_cycle", int'(bus.done), 0);
    check("spikes_stable", int'(bus.spikes), spk);
  endtask

  initial begin
    int spk;
    int exp_spk;
    int val;
    int ndone;
    int first;

    bus.step = 1'b0;
    bus.current = '0;
    bus.threshold = '0;
    bus.leak_shift = '0;
    bus.refract = '0;
    bus.rd_idx = '0;

    // Reset state
    do_reset();
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_spikes", int'(bus.spikes), 0);
    for (int i = 0; i < N; i++) begin
      read_mem(i, val);
      check("rst_mem", val, 0);
    end

    // Integration table: currents 120, threshold 200, leak_shift 1, refract 2
    tbl[0] = '{32'h78787878, 200, 1, 2, 0, 120};
    tbl[1] = '{32'h78787878, 200, 1, 2, 0, 180};
    tbl[2] = '{32'h78787878, 200, 1, 2, 15, 0};
`ifdef LIF_REFRACTORY_EN
    tbl[3] = '{32'h78787878, 200, 1, 2, 0, 0};
    tbl[4] = '{32'h78787878, 200, 1, 2, 0, 0};
    tbl[5] = '{32'h78787878, 200, 1, 2, 0, 120};
`else
    tbl[3] = '{32'h78787878, 200, 1, 2, 0, 120};
    tbl[4] = '{32'h78787878, 200, 1, 2, 0, 180};
    tbl[5] = '{32'h78787878, 200, 1, 2, 15, 0};
`endif
    do_reset();
    for (int t = 0; t < 6; t++) begin
      run_step(tbl[t].cur, tbl[t].thr, tbl[t].ls, tbl[t].rf, spk, exp_spk);
      check("integ_spikes", spk, tbl[t].exp_spk);
      for (int i = 0; i < N; i++) begin
        read_mem(i, val);
        check("integ_mem", val, tbl[t].exp_mem);
      end
    end

    // Saturation: 200 then clamp at 255, which meets threshold 255
    do_reset();
    run_step(32'hC8C8C8C8, 255, 0, 2, spk, exp_spk);
    check("sat1_spikes", spk, 0);
    read_mem(0, val);
    check("sat1_mem", val, 200);
    run_step(32'hC8C8C8C8, 255, 0, 2, spk, exp_spk);
    check("sat2_spikes", spk, 15);
    read_mem(3, val);
    check("sat2_mem", val, 0);

    // Busy guard: step held 3 cycles gives one sweep
    do_reset();
    bus.current = 32'h0A0A0A0A;
    bus.threshold = 8'd255;
    bus.leak_shift = 3'd0;
    bus.refract = 4'd0;
    ndone = 0;
    first = -1;
    for (int c = 0; c < 3 * N + 6; c++) begin
      bus.step = (c < 3);
      tick();
      if (bus.done) begin
        ndone++;
        if (first < 0) first = c;
      end
    end
    bus.step = 1'b0;
    check("guard_ndone", ndone, 1);
    check("guard_latency", first, N);
    read_mem(1, val);
    check("guard_mem", val, 10);

    // Reset mid-sweep
    do_reset();
    run_step(32'h64646464, 255, 0, 0, spk, exp_spk);
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
    tick();
    reset_n = 1'b0;
    tick();
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_done", int'(bus.done), 0);
    reset_n = 1'b1;
    model_clear();
    ndone = 0;
    for (int c = 0; c < 2 * N; c++) begin
      tick();
      if (bus.done) ndone++;
    end
    check("midrst_nodone", ndone, 0);
    for (int i = 0; i < N; i++) begin
      read_mem(i, val);
      check("midrst_mem", val, 0);
    end

    // Mixed channels {0,50,250,120}
    do_reset();
    run_step(32'h78FA3200, 200, 1, 2, spk, exp_spk);
    check("mixed_spikes", spk, 4);
    read_mem(1, val);
    check("mixed_mem1", val, 50);
    read_mem(3, val);
    check("mixed_mem3", val, 120);

    // Randomised sweeps against the model
    do_reset();
    for (int t = 0; t < 40; t++) begin
      logic [31:0] cur;
      int thr;
      cur = $urandom;
      thr = (t == 5) ? 0 : int'($urandom_range(60, 255));
      run_step(cur, thr, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), spk, exp_spk);
      check("rand_spikes", spk, exp_spk);
      for (int i = 0; i < N; i++) begin
        read_mem(i, val);
        check("rand_mem", val, m_mem[i]);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lif_array.md
# lif_array

Time-multiplexed array of N leaky integrate-and-fire neurons that share one update datapath. Each neuron's membrane state is stored in a register file. On every `step` the block sweeps all neurons once, applying leak, input current, threshold and reset. It then publishes a spike vector with a one-cycle `done` strobe. It sits between the input encoder and the spike router, and replaces the single-neuron block as the network's integration stage.

## Interface
Parameters:
- `WIDTH`, 8, membrane/current/threshold width (unsigned).
- `N`, 4, neuron count (≥2).
- `IDX_W`, `$clog2(N)`, neuron index width.
- `REF_W`, 4, refractory counter width.

Ports:
- `clk` in 1: clock.
- `reset_n` in 1: reset, synchronous, active-low.
- `step` in 1: start one sweep; accepted only when `busy`=0.
- `current` in N*WIDTH: per-neuron input current, neuron i at bits [i*WIDTH +: WIDTH].
- `threshold` in WIDTH: firing threshold.
- `leak_shift` in 3: leak = state >> leak_shift; 0 disables leak.
- `refract` in REF_W: refractory steps after a spike.
- `busy` out 1: sweep in progress.
- `done` out 1: one-cycle strobe; `spikes` are valid and new.
- `spikes` out N: bit i set if neuron i fired in the last sweep.
- `rd_idx` in IDX_W: membrane readout index.
- `rd_state` out WIDTH: registered membrane of neuron `rd_idx`.

## Operation
- FSM states: IDLE, RUN, DONE. IDLE→RUN on `step`&&!`busy`. RUN holds for N cycles while `idx` counts 0..N-1. RUN→DONE after idx=N-1. DONE→IDLE unconditionally.
- On acceptance, `current`, `threshold`, `leak_shift` and `refract` are latched. Input changes during the sweep have no effect.
- Per-neuron update in RUN, with s = stored state, c = latched current:
  - If ref_cnt≠0: ref_cnt−1, state←0, no spike.
  - Else: v = s − (leak_shift ? s>>leak_shift : 0). Then n = sat(v + c), saturating at 2^WIDTH−1.
  - If n ≥ threshold: spike=1, state←0, ref_cnt←refract. Otherwise state←n.
- Arithmetic: the add is computed in WIDTH+1 bits and clamped. Subtraction cannot underflow. threshold=0 fires every non-refractory neuron.
- Spike bits accumulate in a shadow vector during RUN. They are copied to `spikes` in DONE, so `spikes` is stable between `done` strobes.
- `step` while busy is ignored and is not queued.
- `rd_state` tracks the stored value and reflects updates made in RUN.

## Timing
- Reset values: all membranes and ref_cnt 0, `busy`=0, `done`=0, `spikes`=0, `rd_state`=0, FSM IDLE.
- `step` is sampled at edge T. `busy`=1 from T+1 through T+N+1. `done`=1 and `spikes` are updated at T+N+1. The earliest next accepted `step` is at T+N+2.
- Throughput: one sweep per N+2 cycles.
- `rd_state` latency: 1 cycle from `rd_idx`.
- `reset_n` low mid-sweep aborts the sweep: no `done`, state is cleared in the same edge.

## Configuration
- `LIF_REFRACTORY_EN` defined: ref_cnt storage and `refract` behave as above.
- Not defined: no ref_cnt registers. The `refract` port is present but ignored. A spiking neuron resets to 0 and integrates normally on the next sweep.

## Structure
- Package `lif_pkg`: FSM state enum (IDLE/RUN/DONE) and the saturating-add function, parameterised by width.
- Sub-module `lif_update`: purely combinational single-neuron update. Inputs: s, c, threshold, leak_shift, ref_cnt, refract. Outputs: next state, next ref_cnt, spike. `lif_array` holds the FSM, index counter, register files and output registers.

## Test plan
- Integration with W=8, N=4, threshold=200, leak_shift=1, refract=2, all currents 120, with the macro defined:
  - Steps 1–2: membranes 120, then 180, no spike.
  - Step 3: `spikes`=4'b1111.
  - Steps 4–5: membranes 0, no spikes.
  - Step 6: membranes 120.
- Saturation: leak_shift=0, threshold=255, current 200 → step 1 gives 200; step 2 gives membrane 255 clamped and a spike.
- Busy guard: `step` held high for 3 cycles → exactly one `done`, exactly N+1 cycles after the first acceptance.
- Reset mid-sweep: `reset_n` low at T+2 → no `done`, all `rd_state` reads are 0, `busy`=0 next cycle.
- Mixed channels: currents {0,50,250,120}, threshold=200 → step 1 `spikes`=4'b0100, `rd_state`[1]=50.
- Macro undefined: the integration test above gives a spike at step 3 and membrane 120 at step 4.
